// File: rtl/send_buffer_ctrl_pkg.sv
// Shared types and constants for the key-driven UART send buffer.
package send_ctrl_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BURST  = 1'b1;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

endpackage

// File: rtl/send_buffer_ctrl_if.sv
// Valid/ready byte channel between the send buffer and the UART TX front end.
interface send_buffer_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/send_buffer_ctrl_btn_edge_sync.sv
// Key synchroniser followed by a rising-edge detector; a held key yields one pulse.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/send_buffer_ctrl.sv
// Editable DEPTH-entry transmit buffer: keys edit entries in idle, then one entry
// or the whole buffer is streamed over the valid/ready channel.
module send_buffer_ctrl
    import send_ctrl_pkg::*;
#(
    parameter int  DATA_W      = 8,
    parameter int  DEPTH       = 8,
    parameter int  SAT_MODE    = 0,
    parameter int  SYNC_STAGES = 2,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_btn_next,
    input  logic                i_btn_prev,
    input  logic                i_btn_inc,
    input  logic                i_btn_dec,
    input  logic                i_btn_send,
    input  logic                i_burst_mode,
    send_buffer_ctrl_if.master  tx_if,
    output logic [DATA_W-1:0]   o_preview_data,
    output logic [IDX_W-1:0]    o_preview_index,
    output logic                o_busy,
    output logic                o_send_done
);
    localparam logic [DATA_W-1:0] MAX_VAL  = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            r_state, w_state_next;
    logic [IDX_W-1:0]  r_index, w_index_next;
    logic [IDX_W-1:0]  r_ptr, w_ptr_next;
    logic              r_burst, w_burst_next;
    logic              r_send_done, w_done_next;
    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [DATA_W-1:0] r_preview_data;
    logic [IDX_W-1:0]  r_preview_index;

    logic              w_ev_next, w_ev_prev, w_ev_inc, w_ev_dec, w_ev_send;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data, w_cur, w_tx_word;
    logic              w_tx_valid;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_next (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_next), .o_pulse(w_ev_next));
    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_prev (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_prev), .o_pulse(w_ev_prev));
    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc  (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_inc),  .o_pulse(w_ev_inc));
    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dec  (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_dec),  .o_pulse(w_ev_dec));
    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_send (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_send), .o_pulse(w_ev_send));

    assign w_cur      = r_ram[r_index];
    assign w_tx_word  = r_ram[r_ptr];
    assign w_tx_valid = (r_state == ST_SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_ptr       <= '0;
            r_burst     <= MODE_SINGLE;
            r_send_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_index     <= w_index_next;
            r_ptr       <= w_ptr_next;
            r_burst     <= w_burst_next;
            r_send_done <= w_done_next;
        end
    end

    // A send event wins the cycle; edits always use the index from before any move.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_ptr_next   = r_ptr;
        w_burst_next = r_burst;
        w_done_next  = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_data    = w_cur;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_send) begin
                    w_state_next = ST_SEND;
                    w_burst_next = i_burst_mode;
                    w_ptr_next   = (i_burst_mode == MODE_SINGLE) ? r_index : '0;
                end else begin
                    if (w_ev_inc && !w_ev_dec) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = (w_cur == MAX_VAL) ? ((SAT_MODE == SAT_CLAMP) ? MAX_VAL : '0)
                                                       : w_cur + 1'b1;
                    end else if (w_ev_dec && !w_ev_inc) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = (w_cur == '0) ? ((SAT_MODE == SAT_WRAP) ? MAX_VAL : '0)
                                                  : w_cur - 1'b1;
                    end
                    if (w_ev_next && !w_ev_prev) begin
                        w_index_next = r_index + 1'b1;
                    end else if (w_ev_prev && !w_ev_next) begin
                        w_index_next = r_index - 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (w_tx_valid && tx_if.tx_ready) begin
                    if (r_burst == MODE_BURST && r_ptr != LAST_IDX) begin
                        w_ptr_next = r_ptr + 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= '0;
            end
            r_preview_data  <= '0;
            r_preview_index <= '0;
        end else begin
            if (w_wr_en) begin
                r_ram[r_index] <= w_wr_data;
            end
            r_preview_data  <= w_cur;
            r_preview_index <= r_index;
        end
    end

    assign tx_if.tx_valid  = w_tx_valid;
    assign tx_if.tx_data   = w_tx_valid ? w_tx_word : '0;
    assign o_busy          = w_tx_valid;
    assign o_send_done     = r_send_done;
    assign o_preview_data  = r_preview_data;
    assign o_preview_index = r_preview_index;

endmodule

// File: tb/tb_send_buffer_ctrl.sv
// Directed self-checking bench: one wrapping instance for editing/sending, one clamping instance.
module tb_send_buffer_ctrl;
    import send_ctrl_pkg::*;

    localparam logic [4:0] K_NEXT = 5'b00001;
    localparam logic [4:0] K_PREV = 5'b00010;
    localparam logic [4:0] K_INC  = 5'b00100;
    localparam logic [4:0] K_DEC  = 5'b01000;
    localparam logic [4:0] K_SEND = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] keys0, keys1;
    logic       burstMode0;
    logic       toggleReady;
    logic [7:0] previewData0, previewData1;
    logic [2:0] previewIndex0, previewIndex1;
    logic       busy0, busy1, sendDone0, sendDone1;

    int         checkCount = 0;
    int         failCount  = 0;
    int         doneCount  = 0;
    logic [7:0] hsData[$];
    int         expIdx0;
    int         expRam0 [8];

    send_buffer_ctrl_if #(.DATA_W(8)) if0 ();
    send_buffer_ctrl_if #(.DATA_W(8)) if1 ();

    send_buffer_ctrl #(.DATA_W(8), .DEPTH(8), .SAT_MODE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_btn_next(keys0[0]), .i_btn_prev(keys0[1]), .i_btn_inc(keys0[2]),
        .i_btn_dec(keys0[3]), .i_btn_send(keys0[4]), .i_burst_mode(burstMode0),
        .tx_if(if0.master),
        .o_preview_data(previewData0), .o_preview_index(previewIndex0),
        .o_busy(busy0), .o_send_done(sendDone0)
    );

    send_buffer_ctrl #(.DATA_W(8), .DEPTH(8), .SAT_MODE(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_btn_next(keys1[0]), .i_btn_prev(keys1[1]), .i_btn_inc(keys1[2]),
        .i_btn_dec(keys1[3]), .i_btn_send(keys1[4]), .i_burst_mode(1'b0),
        .tx_if(if1.master),
        .o_preview_data(previewData1), .o_preview_index(previewIndex1),
        .o_busy(busy1), .o_send_done(sendDone1)
    );

    always #5 clk = ~clk;

    // Handshakes and done pulses are recorded exactly at the clock edge that commits them.
    always @(posedge clk) begin
        if (if0.tx_valid && if0.tx_ready) hsData.push_back(if0.tx_data);
        if (sendDone0) doneCount++;
    end

    always @(negedge clk) begin
        if (toggleReady) if0.tx_ready = ~if0.tx_ready;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] mask, input bit onSat);
        if (onSat) keys1 = mask; else keys0 = mask;
        repeat (3) @(negedge clk);
        if (onSat) keys1 = '0; else keys0 = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic setEntry(input int idx, input int val);
        while (expIdx0 != idx) begin
            applyStimulus(K_NEXT, 1'b0);
            expIdx0 = (expIdx0 + 1) % 8;
        end
        while (expRam0[idx] < val) begin
            applyStimulus(K_INC, 1'b0);
            expRam0[idx]++;
        end
        while (expRam0[idx] > val) begin
            applyStimulus(K_DEC, 1'b0);
            expRam0[idx]--;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; keys0 = '0; keys1 = '0; burstMode0 = 1'b0; toggleReady = 1'b0;
        if0.tx_ready = 1'b0; if1.tx_ready = 1'b0;
        expIdx0 = 0;
        for (int i = 0; i < 8; i++) expRam0[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstPreviewData", 32'(previewData0), 32'h0);
        checkOutput("rstPreviewIdx", 32'(previewIndex0), 32'h0);
        checkOutput("rstTxValid", 32'(if0.tx_valid), 32'h0);
        checkOutput("rstTxData", 32'(if0.tx_data), 32'h0);
        checkOutput("rstBusy", 32'(busy0), 32'h0);
        checkOutput("rstDone", 32'(sendDone0), 32'h0);

        $display("[TB] editing and wrap-around");
        repeat (3) applyStimulus(K_INC, 1'b0);
        checkOutput("inc3Data", 32'(previewData0), 32'h03);
        applyStimulus(K_NEXT, 1'b0);
        checkOutput("nextIdx", 32'(previewIndex0), 32'h1);
        checkOutput("nextData", 32'(previewData0), 32'h00);
        applyStimulus(K_DEC, 1'b0);
        checkOutput("decAtZeroWrap", 32'(previewData0), 32'hFF);
        applyStimulus(K_DEC, 1'b0);
        checkOutput("decSecond", 32'(previewData0), 32'hFE);
        applyStimulus(K_INC, 1'b0);
        applyStimulus(K_INC, 1'b0);
        checkOutput("incAtMaxWrap", 32'(previewData0), 32'h00);
        applyStimulus(K_INC | K_DEC, 1'b0);
        checkOutput("incDecCancel", 32'(previewData0), 32'h00);
        applyStimulus(K_NEXT | K_PREV, 1'b0);
        checkOutput("nextPrevCancel", 32'(previewIndex0), 32'h1);
        applyStimulus(K_PREV, 1'b0);
        checkOutput("prevIdx", 32'(previewIndex0), 32'h0);
        checkOutput("entry0Kept", 32'(previewData0), 32'h03);
        applyStimulus(K_PREV, 1'b0);
        checkOutput("prevWrapIdx", 32'(previewIndex0), 32'h7);
        applyStimulus(K_NEXT, 1'b0);
        checkOutput("nextWrapIdx", 32'(previewIndex0), 32'h0);
        expRam0[0] = 3;

        $display("[TB] saturating instance");
        applyStimulus(K_DEC, 1'b1);
        checkOutput("satDecAtZero", 32'(previewData1), 32'h00);
        applyStimulus(K_NEXT, 1'b1);
        repeat (256) applyStimulus(K_INC, 1'b1);
        checkOutput("satInc256", 32'(previewData1), 32'hFF);
        checkOutput("satIdx", 32'(previewIndex1), 32'h1);

        $display("[TB] single send with stalled ready");
        setEntry(2, 8'h5A);
        checkOutput("preSendData", 32'(previewData0), 32'h5A);
        checkOutput("preSendIdx", 32'(previewIndex0), 32'h2);
        hsData.delete(); doneCount = 0;
        keys0 = K_SEND;
        repeat (3) @(negedge clk);
        keys0 = '0;
        for (int i = 0; i < 10 && !if0.tx_valid; i++) @(negedge clk);
        checkOutput("singleValidRise", 32'(if0.tx_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallValid", 32'(if0.tx_valid), 32'h1);
            checkOutput("stallData", 32'(if0.tx_data), 32'h5A);
            checkOutput("stallBusy", 32'(busy0), 32'h1);
        end
        if0.tx_ready = 1'b1;
        @(negedge clk);
        checkOutput("singleValidDrop", 32'(if0.tx_valid), 32'h0);
        checkOutput("singleBusyDrop", 32'(busy0), 32'h0);
        checkOutput("singleDonePulse", 32'(sendDone0), 32'h1);
        @(negedge clk);
        if0.tx_ready = 1'b0;
        checkOutput("singleDoneEnd", 32'(sendDone0), 32'h0);
        checkOutput("singleHsCount", 32'(hsData.size()), 32'h1);
        checkOutput("singleHsData", 32'(hsData.size() > 0 ? hsData[0] : 8'h00), 32'h5A);
        checkOutput("singleDoneCount", 32'(doneCount), 32'h1);

        $display("[TB] burst with toggling ready");
        for (int i = 0; i < 8; i++) setEntry(i, 8'h10 + i);
        checkOutput("preBurstIdx", 32'(previewIndex0), 32'h7);
        checkOutput("preBurstData", 32'(previewData0), 32'h17);
        hsData.delete(); doneCount = 0;
        burstMode0 = 1'b1; toggleReady = 1'b1;
        keys0 = K_SEND;
        repeat (3) @(negedge clk);
        keys0 = K_INC | K_NEXT;
        repeat (3) @(negedge clk);
        keys0 = '0; burstMode0 = 1'b0;
        for (int i = 0; i < 200 && doneCount == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        toggleReady = 1'b0; if0.tx_ready = 1'b0;
        checkOutput("burstDoneCount", 32'(doneCount), 32'h1);
        checkOutput("burstHsCount", 32'(hsData.size()), 32'h8);
        for (int i = 0; i < hsData.size() && i < 8; i++)
            checkOutput($sformatf("burstHs%0d", i), 32'(hsData[i]), 32'(8'h10 + i));
        checkOutput("burstBusyEnd", 32'(busy0), 32'h0);
        checkOutput("busyKeysIdx", 32'(previewIndex0), 32'h7);
        checkOutput("busyKeysData", 32'(previewData0), 32'h17);

        $display("[TB] reset during burst");
        hsData.delete(); doneCount = 0;
        burstMode0 = 1'b1; toggleReady = 1'b1;
        keys0 = K_SEND;
        repeat (3) @(negedge clk);
        keys0 = '0;
        for (int i = 0; i < 10 && !if0.tx_valid; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("preResetValid", 32'(if0.tx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", 32'(if0.tx_valid), 32'h0);
        checkOutput("midResetBusy", 32'(busy0), 32'h0);
        toggleReady = 1'b0; if0.tx_ready = 1'b0; burstMode0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postResetIdx", 32'(previewIndex0), 32'h0);
        expIdx0 = 0;
        for (int i = 0; i < 8; i++) expRam0[i] = 0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("postResetEntry%0d", expIdx0), 32'(previewData0), 32'h0);
            applyStimulus(K_NEXT, 1'b0);
            expIdx0 = (expIdx0 + 1) % 8;
        end
        checkOutput("postResetWalkIdx", 32'(previewIndex0), 32'h0);

        $display("[TB] send and inc in the same cycle");
        applyStimulus(K_INC, 1'b0);
        checkOutput("preCollideData", 32'(previewData0), 32'h01);
        hsData.delete(); doneCount = 0;
        if0.tx_ready = 1'b1;
        keys0 = K_SEND | K_INC;
        repeat (3) @(negedge clk);
        keys0 = '0;
        for (int i = 0; i < 50 && doneCount == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        if0.tx_ready = 1'b0;
        checkOutput("collideDone", 32'(doneCount), 32'h1);
        checkOutput("collideHsCount", 32'(hsData.size()), 32'h1);
        checkOutput("collideHsData", 32'(hsData.size() > 0 ? hsData[0] : 8'h00), 32'h01);
        checkOutput("collideEntryKept", 32'(previewData0), 32'h01);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
